preg_release_sched: RTL and testbench

Release scheduler for physical registers. It sits between the ROB commit stage, which can retire up to two destination physical registers per cycle, and the free list, which has a single write port. A small in-order queue buffers released register indexes and drains them into the free list one per cycle while honoring its full flag. A drain handshake lets the recovery logic wait until every committed release has reached the free list.

---
 rtl/backend_types.sv | 14 +
 rtl/preg_release_fifo.sv | 57 +++++
 rtl/preg_release_sched.sv | 93 +++++++++
 tb/tb_preg_release_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/backend_types.sv
// Shared backend types: physical register width, release queue depth and the
// release scheduler state encoding.
package backend_types;

  localparam int PHYS_REG_WIDTH      = 7;
  localparam int RELEASE_QUEUE_DEPTH = 4;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    DRAIN  = 2'd1,
    DONE   = 2'd2
  } rel_state_t;

endpackage

// File: rtl/preg_release_fifo.sv
// Two-write / one-read circular buffer with occupancy count. Entry 0 of a dual
// write lands at the tail, entry 1 right behind it; a lone push1 takes the tail.
module preg_release_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 7,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0,
  input  logic          push1,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_1;
  logic [1:0]    n_push;
  logic [W-1:0]  first_data;

  assign n_push     = {1'b0, push0} + {1'b0, push1};
  assign wr_ptr_1   = wr_ptr + 1'b1;
  assign first_data = push0 ? data0 : data1;
  assign head       = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      wr_ptr <= wr_ptr + AW'(n_push);
      count  <= count + CW'(n_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push0 || push1) mem[wr_ptr] <= first_data;
    if (push0 && push1) mem[wr_ptr_1] <= data1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count + CW'(n_push) - CW'(pop) <= CW'(DEPTH));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: rtl/preg_release_sched.sv
// Physical register release scheduler: buffers up to two commit releases per
// cycle and drains them one per cycle into the free list. RELEASE_BYPASS_EN
// lets lane 0 skip the queue when it is empty.
module preg_release_sched
  import backend_types::*;
#(
  parameter  int RQ_DEPTH = RELEASE_QUEUE_DEPTH,
  localparam int CW       = $clog2(RQ_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     rel_valid,
  input  logic [1:0][PHYS_REG_WIDTH-1:0] rel_preg,
  output logic                           rel_ready,
  output logic                           fl_wen,
  output logic [PHYS_REG_WIDTH-1:0]      fl_wdata,
  input  logic                           fl_full,
  input  logic                           drain_req,
  output logic                           drain_done,
  output logic [CW-1:0]                  rq_count,
  output rel_state_t                     state_dbg
);

  // Handshake: a lane is taken in any cycle where rel_valid[i] && rel_ready;
  // commit holds rel_valid/rel_preg stable while rel_ready is low. The free
  // list takes fl_wdata in any cycle where fl_wen && !fl_full.

  localparam logic [CW-1:0] READY_MAX = CW'(RQ_DEPTH - 2);

  rel_state_t                state;
  rel_state_t                state_next;
  logic [CW-1:0]             count;
  logic [PHYS_REG_WIDTH-1:0] head;
  logic [1:0]                accept;
  logic                      bypass;
  logic                      push0;
  logic                      push1;
  logic                      pop;
  logic                      empty;

  assign empty = (count == '0);

  // rst gates the handshake so nothing is offered while reset is held.
  assign rel_ready = !rst && (state == NORMAL) && (count <= READY_MAX);
  assign accept    = rel_ready ? rel_valid : 2'b00;

`ifdef RELEASE_BYPASS_EN
  assign bypass = !rst && (state == NORMAL) && empty && !fl_full && rel_valid[0];
`else
  assign bypass = 1'b0;
`endif

  assign push0 = accept[0] && !bypass;
  assign push1 = accept[1];
  assign pop   = !empty && !fl_full;

  assign fl_wen     = !empty || bypass;
  assign fl_wdata   = bypass ? rel_preg[0] : head;
  assign rq_count   = count;
  assign drain_done = (state == DONE);
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= NORMAL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      NORMAL:  if (drain_req) state_next = DRAIN;
      DRAIN:   if (empty) state_next = DONE;
      DONE:    state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  preg_release_fifo #(
    .DEPTH (RQ_DEPTH),
    .W     (PHYS_REG_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0),
    .push1 (push1),
    .data0 (rel_preg[0]),
    .data1 (rel_preg[1]),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_preg_release_sched.sv
// Self-checking bench for preg_release_sched: table vectors plus hand-written
// sequences, with a queue model of everything the free list should receive.
module tb_preg_release_sched;
  import backend_types::*;

  localparam int DEPTH = RELEASE_QUEUE_DEPTH;
  localparam int W     = PHYS_REG_WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clk;
  logic                 rst;
  logic [1:0]           rel_valid;
  logic [1:0][W-1:0]    rel_preg;
  logic                 rel_ready;
  logic                 fl_wen;
  logic [W-1:0]         fl_wdata;
  logic                 fl_full;
  logic                 drain_req;
  logic                 drain_done;
  logic [CW-1:0]        rq_count;
  rel_state_t           state_dbg;

  preg_release_sched #(.RQ_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rel_valid  (rel_valid),
    .rel_preg   (rel_preg),
    .rel_ready  (rel_ready),
    .fl_wen     (fl_wen),
    .fl_wdata   (fl_wdata),
    .fl_full    (fl_full),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .rq_count   (rq_count),
    .state_dbg  (state_dbg)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q[$];
  int           mstate = 0;
  logic         m_ready_last;
  logic         m_done_last;

  typedef struct {
    logic [1:0]    v;
    logic [W-1:0]  p0;
    logic [W-1:0]  p1;
    logic          full;
    logic          exp_ready;
    logic [CW-1:0] exp_count;
  } vec_t;

  vec_t tab[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [W-1:0] p0, input logic [W-1:0] p1,
                       input logic full, input logic dreq);
    rel_valid   = v;
    rel_preg[0] = p0;
    rel_preg[1] = p1;
    fl_full     = full;
    drain_req   = dreq;
  endtask

  // scoreboard: compare this cycle's outputs, then advance the model one edge
  task automatic settle();
    int           sz;
    logic         er;
    logic         byp;
    logic         ew;
    logic [W-1:0] ed;
    #1;
    sz = exp_q.size();
    er = (mstate == 0) && (DEPTH - sz >= 2);
`ifdef RELEASE_BYPASS_EN
    byp = (sz == 0) && !fl_full && (mstate == 0) && rel_valid[0];
`else
    byp = 1'b0;
`endif
    ew = (sz != 0) || byp;
    chk("rel_ready", rel_ready, er);
    chk("fl_wen", fl_wen, ew);
    chk("drain_done", drain_done, mstate == 2);
    chk("rq_count", rq_count, sz);
    chk("state", state_dbg, mstate);
    if (ew) begin
      ed = byp ? rel_preg[0] : exp_q[0];
      chk("fl_wdata", fl_wdata, ed);
    end
    if (drain_done) done_cnt++;
    m_ready_last = er;
    m_done_last  = (mstate == 2);
    if (!byp && sz != 0 && !fl_full) void'(exp_q.pop_front());
    if (er) begin
      if (rel_valid[0] && !byp) exp_q.push_back(rel_preg[0]);
      if (rel_valid[1]) exp_q.push_back(rel_preg[1]);
    end
    case (mstate)
      0: if (drain_req) mstate = 1;
      1: if (sz == 0) mstate = 2;
      default: mstate = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic full);
    for (int i = 0; i < n; i++) begin
      drive(2'b00, '0, '0, full, 1'b0);
      settle();
    end
  endtask

  initial begin
    logic [1:0]   rv;
    logic [W-1:0] rp0, rp1;
    logic         pend;
    logic         seen;

    tab[0] = '{2'b01, 7'd40, 7'd0,  1'b0, 1'b1, 3'd0};
    tab[1] = '{2'b00, 7'd0,  7'd0,  1'b0, 1'b1, 3'd1};
    tab[2] = '{2'b11, 7'd41, 7'd42, 1'b0, 1'b1, 3'd0};
    tab[3] = '{2'b11, 7'd43, 7'd44, 1'b0, 1'b1, 3'd2};
    tab[4] = '{2'b11, 7'd45, 7'd46, 1'b0, 1'b0, 3'd3};
    tab[5] = '{2'b11, 7'd45, 7'd46, 1'b0, 1'b1, 3'd2};
    tab[6] = '{2'b00, 7'd0,  7'd0,  1'b0, 1'b0, 3'd3};
    tab[7] = '{2'b00, 7'd0,  7'd0,  1'b0, 1'b1, 3'd2};
    tab[8] = '{2'b00, 7'd0,  7'd0,  1'b0, 1'b1, 3'd1};
    tab[9] = '{2'b00, 7'd0,  7'd0,  1'b0, 1'b1, 3'd0};

    rst = 1'b1;
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    drive(2'b11, 7'd1, 7'd2, 1'b0, 1'b1);
    #2;
    chk("reset_rel_ready", rel_ready, 1'b0);
    chk("reset_fl_wen", fl_wen, 1'b0);
    chk("reset_drain_done", drain_done, 1'b0);
    chk("reset_rq_count", rq_count, 0);
    @(negedge clk);
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;

    // table: single release latency and dual-lane back-pressure
    for (int i = 0; i < 10; i++) begin
      drive(tab[i].v, tab[i].p0, tab[i].p1, tab[i].full, 1'b0);
`ifndef RELEASE_BYPASS_EN
      #1;
      chk("tab_rel_ready", rel_ready, tab[i].exp_ready);
      chk("tab_rq_count", rq_count, tab[i].exp_count);
`endif
      settle();
    end

    // free list full holds the head with three entries queued
    drive(2'b11, 7'd50, 7'd51, 1'b1, 1'b0); settle();
    drive(2'b01, 7'd52, 7'd0,  1'b1, 1'b0); settle();
    idle(5, 1'b1);
    idle(4, 1'b0);

    // drain while commit keeps both lanes requesting
    drive(2'b01, 7'd60, 7'd0, 1'b0, 1'b0); settle();
    drive(2'b11, 7'd61, 7'd62, 1'b0, 1'b1); settle();
    done_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      drive(2'b11, 7'd63, 7'd64, 1'b0, 1'b0);
      settle();
      seen = m_done_last;
    end
    chk("drain_done_seen", seen, 1'b1);
    drive(2'b11, 7'd63, 7'd64, 1'b0, 1'b0); settle();
    idle(4, 1'b0);
    chk("drain_done_pulses", done_cnt, 1);

    // asynchronous reset mid-cycle with three entries queued
    drive(2'b11, 7'd80, 7'd81, 1'b1, 1'b0); settle();
    drive(2'b01, 7'd82, 7'd0,  1'b1, 1'b0); settle();
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rq_count", rq_count, 0);
    chk("async_rst_fl_wen", fl_wen, 1'b0);
    chk("async_rst_rel_ready", rel_ready, 1'b0);
    @(negedge clk);
    exp_q.delete();
    mstate = 0;
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(2'b01, 7'd90, 7'd0, 1'b0, 1'b0); settle();
    idle(2, 1'b0);

    // pointer wrap with single releases
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(2'b01, W'(32 + i), '0, 1'b0, 1'b0);
      settle();
    end
    idle(3, 1'b0);

    // random traffic; requests held stable until accepted
    pend = 1'b0;
    rv = '0; rp0 = '0; rp1 = '0;
    for (int i = 0; i < 80; i++) begin
      if (!pend) begin
        rv  = 2'($urandom_range(0, 3));
        rp0 = W'($urandom_range(0, 127));
        rp1 = W'($urandom_range(0, 127));
      end
      drive(rv, rp0, rp1, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      settle();
      pend = (rv != 2'b00) && !m_ready_last;
    end
    for (int i = 0; i < 3 * DEPTH && (exp_q.size() != 0 || mstate != 0); i++) idle(1, 1'b0);
    idle(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
